// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_ctrl
//  Description : Multi-cycle control sequencer for the ONC-16 core. Steps each
//                instruction through IF, ID, EX, MEM and WB and gates the
//                decoder's combinational classification onto the IR, PC,
//                register-file, flag-register and data-memory enables so
//                that each of them is committed only in its proper cycle.
//  Ports       : clk, rst (async, active-high)
//                run                     - start/continue at boundaries
//                imem_ready, dmem_ready  - memory acknowledge handshakes
//                dec_*                   - decoder classification of the IR
//                br_taken                - branch condition from flag reg
//                imem_req, ir_we         - fetch request / IR load strobe
//                dmem_req, dmem_we       - data memory request / write
//                rf_we, fr_we            - register / flag commit strobes
//                pc_we, pc_sel           - PC update and source select
//                retired                 - retired-instruction counter
//                fault                   - sticky memory timeout indicator
//                state                   - current state (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             dec_rf_we,
    input  logic             dec_is_ld,
    input  logic             dec_is_st,
    input  logic             dec_fr_de,
    input  logic             dec_fr_upd,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             fr_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [2:0]       state
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_if    = 3'd1;
    localparam logic [2:0] c_st_id    = 3'd2;
    localparam logic [2:0] c_st_ex    = 3'd3;
    localparam logic [2:0] c_st_mem   = 3'd4;
    localparam logic [2:0] c_st_wb    = 3'd5;
    localparam logic [2:0] c_st_fault = 3'd6;

    localparam int                  c_wait_w   = $clog2(WAIT_MAX + 1);
    localparam logic [c_wait_w-1:0] c_wait_lim = c_wait_w'(WAIT_MAX);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);
    localparam logic [CNT_W-1:0]    c_cnt_one  = CNT_W'(1);

    logic [2:0]          r_state;
    logic [c_wait_w-1:0] r_wait;
    logic [CNT_W-1:0]    r_retired;

    logic [2:0] w_next;
    logic [2:0] w_boundary;
    logic       w_imem_req;
    logic       w_ir_we;
    logic       w_dmem_req;
    logic       w_dmem_we;
    logic       w_rf_we;
    logic       w_fr_we;
    logic       w_pc_we;
    logic       w_pc_sel;
    logic       w_timeout;

    // run is only looked at when an instruction has fully retired.
    assign w_boundary = run ? c_st_if : c_st_idle;

    // The wait counter holds WAIT_MAX after WAIT_MAX unacknowledged cycles;
    // a request still unacknowledged in that cycle faults, while a ready
    // arriving in that same cycle completes normally.
    assign w_timeout = (r_wait == c_wait_lim);

    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_rf_we    = 1'b0;
        w_fr_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (run) begin
                    w_next = c_st_if;
                end
            end
            c_st_if: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = c_st_id;
                end else if (w_timeout) begin
                    w_next = c_st_fault;
                end
            end
            c_st_id: begin
                // Decoder outputs settle from the freshly loaded IR.
                w_next = c_st_ex;
            end
            c_st_ex: begin
                if (dec_fr_de) begin
                    // Branches retire here; no register or flag commit.
                    w_pc_we  = 1'b1;
                    w_pc_sel = br_taken;
                    w_next   = w_boundary;
                end else if (dec_is_ld || dec_is_st) begin
                    w_next = c_st_mem;
                end else begin
                    w_next = c_st_wb;
                end
            end
            c_st_mem: begin
                w_dmem_req = 1'b1;
                // LD+ST together is illegal and is handled as a load.
                w_dmem_we  = dec_is_st & ~dec_is_ld;
                if (dmem_ready) begin
                    if (dec_is_ld) begin
                        w_next = c_st_wb;
                    end else begin
                        w_pc_we = 1'b1;
                        w_next  = w_boundary;
                    end
                end else if (w_timeout) begin
                    w_next = c_st_fault;
                end
            end
            c_st_wb: begin
                w_rf_we = dec_rf_we;
                w_fr_we = dec_fr_upd;
                w_pc_we = 1'b1;
                w_next  = w_boundary;
            end
            c_st_fault: begin
                w_next = c_st_fault;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_pc_we) begin
                r_retired <= r_retired + c_cnt_one;
            end
            // Counts only while a memory request is held without ready;
            // any state change (including entry to IF/MEM) clears it.
            if (((r_state == c_st_if) || (r_state == c_st_mem)) && (w_next == r_state)) begin
                r_wait <= r_wait + c_wait_one;
            end else begin
                r_wait <= '0;
            end
        end
    end

    // Outputs decode directly from the state register, so an async reset
    // forces every strobe low immediately.
    assign imem_req = w_imem_req;
    assign ir_we    = w_ir_we;
    assign dmem_req = w_dmem_req;
    assign dmem_we  = w_dmem_we;
    assign rf_we    = w_rf_we;
    assign fr_we    = w_fr_we;
    assign pc_we    = w_pc_we;
    assign pc_sel   = w_pc_sel;
    assign retired  = r_retired;
    assign fault    = (r_state == c_st_fault);
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_seq_ctrl
//  Description : Self-checking bench for cpu_seq_ctrl. A table of per-cycle
//                {inputs, expected state/strobes/retired} records walks a
//                program of ADD, LD, ST, CMPI and branches; hand-written
//                sequences cover fetch timeout, ready at the timeout limit,
//                async reset mid-instruction and counter wrap (CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

    logic clk, rst, run, imem_ready, dmem_ready;
    logic dec_rf_we, dec_is_ld, dec_is_st, dec_fr_de, dec_fr_upd, br_taken;
    logic imem_req, ir_we, dmem_req, dmem_we, rf_we, fr_we, pc_we, pc_sel;
    logic [15:0] retired;
    logic        fault;
    logic [2:0]  state;

    logic x_imem_req, x_ir_we, x_dmem_req, x_dmem_we, x_rf_we, x_fr_we, x_pc_we, x_pc_sel;
    logic [3:0] x_retired;
    logic       x_fault;
    logic [2:0] x_state;

    int n_checks = 0;
    int n_errors = 0;

    cpu_seq_ctrl #(.WAIT_MAX(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dec_rf_we(dec_rf_we), .dec_is_ld(dec_is_ld), .dec_is_st(dec_is_st),
        .dec_fr_de(dec_fr_de), .dec_fr_upd(dec_fr_upd), .br_taken(br_taken),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .fr_we(fr_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .retired(retired), .fault(fault), .state(state)
    );

    // Narrow-counter instance sharing all stimulus, used for the wrap check.
    cpu_seq_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dec_rf_we(dec_rf_we), .dec_is_ld(dec_is_ld), .dec_is_st(dec_is_st),
        .dec_fr_de(dec_fr_de), .dec_fr_upd(dec_fr_upd), .br_taken(br_taken),
        .imem_req(x_imem_req), .ir_we(x_ir_we), .dmem_req(x_dmem_req), .dmem_we(x_dmem_we),
        .rf_we(x_rf_we), .fr_we(x_fr_we), .pc_we(x_pc_we), .pc_sel(x_pc_sel),
        .retired(x_retired), .fault(x_fault), .state(x_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // in  : {run, imem_ready, dmem_ready, rf_we, is_ld, is_st, fr_de, fr_upd, br_taken}
    // outs: {imem_req, ir_we, dmem_req, dmem_we, rf_we, fr_we, pc_we, pc_sel}
    typedef struct {
        string      name;
        logic [8:0] in;
        logic [2:0] st;
        logic [7:0] outs;
        int         ret;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic [8:0] in, input logic [2:0] st,
                       input logic [7:0] outs, input int ret);
        vec_t v;
        v.name = nm; v.in = in; v.st = st; v.outs = outs; v.ret = ret;
        vq.push_back(v);
    endtask

    task automatic apply(input logic [8:0] in);
        {run, imem_ready, dmem_ready, dec_rf_we, dec_is_ld, dec_is_st,
         dec_fr_de, dec_fr_upd, br_taken} = in;
    endtask

    function automatic logic [7:0] dut_outs();
        return {imem_req, ir_we, dmem_req, dmem_we, rf_we, fr_we, pc_we, pc_sel};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(9'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        apply(9'b0);
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'(dut_outs()), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        do_reset();

        // ADD: rf_we=1, fr_upd=1
        add("add_idle", 9'b1_1_0_1_0_0_0_1_0, 3'd0, 8'b0000_0000, 0);
        add("add_if",   9'b1_1_0_1_0_0_0_1_0, 3'd1, 8'b1100_0000, 0);
        add("add_id",   9'b1_1_0_1_0_0_0_1_0, 3'd2, 8'b0000_0000, 0);
        add("add_ex",   9'b1_1_0_1_0_0_0_1_0, 3'd3, 8'b0000_0000, 0);
        add("add_wb",   9'b1_1_0_1_0_0_0_1_0, 3'd5, 8'b0000_1110, 0);
        // LD with three wait cycles
        add("ld_if",    9'b1_1_0_1_1_0_0_0_0, 3'd1, 8'b1100_0000, 1);
        add("ld_id",    9'b1_1_0_1_1_0_0_0_0, 3'd2, 8'b0000_0000, 1);
        add("ld_ex",    9'b1_1_0_1_1_0_0_0_0, 3'd3, 8'b0000_0000, 1);
        add("ld_mem0",  9'b1_1_0_1_1_0_0_0_0, 3'd4, 8'b0010_0000, 1);
        add("ld_mem1",  9'b1_1_0_1_1_0_0_0_0, 3'd4, 8'b0010_0000, 1);
        add("ld_mem2",  9'b1_1_0_1_1_0_0_0_0, 3'd4, 8'b0010_0000, 1);
        add("ld_mem3",  9'b1_1_1_1_1_0_0_0_0, 3'd4, 8'b0010_0000, 1);
        add("ld_wb",    9'b1_1_0_1_1_0_0_0_0, 3'd5, 8'b0000_1010, 1);
        // ST commits in the ready cycle
        add("st_if",    9'b1_1_0_0_0_1_0_0_0, 3'd1, 8'b1100_0000, 2);
        add("st_id",    9'b1_1_0_0_0_1_0_0_0, 3'd2, 8'b0000_0000, 2);
        add("st_ex",    9'b1_1_0_0_0_1_0_0_0, 3'd3, 8'b0000_0000, 2);
        add("st_mem0",  9'b1_1_0_0_0_1_0_0_0, 3'd4, 8'b0011_0000, 2);
        add("st_mem1",  9'b1_1_1_0_0_1_0_0_0, 3'd4, 8'b0011_0010, 2);
        // CMPI: flags only
        add("cmp_if",   9'b1_1_0_0_0_0_0_1_0, 3'd1, 8'b1100_0000, 3);
        add("cmp_id",   9'b1_1_0_0_0_0_0_1_0, 3'd2, 8'b0000_0000, 3);
        add("cmp_ex",   9'b1_1_0_0_0_0_0_1_0, 3'd3, 8'b0000_0000, 3);
        add("cmp_wb",   9'b1_1_0_0_0_0_0_1_0, 3'd5, 8'b0000_0110, 3);
        // Branch taken, then not taken
        add("bt_if",    9'b1_1_0_0_0_0_1_0_1, 3'd1, 8'b1100_0000, 4);
        add("bt_id",    9'b1_1_0_0_0_0_1_0_1, 3'd2, 8'b0000_0000, 4);
        add("bt_ex",    9'b1_1_0_0_0_0_1_0_1, 3'd3, 8'b0000_0011, 4);
        add("bn_if",    9'b1_1_0_0_0_0_1_0_0, 3'd1, 8'b1100_0000, 5);
        add("bn_id",    9'b1_1_0_0_0_0_1_0_0, 3'd2, 8'b0000_0000, 5);
        add("bn_ex",    9'b1_1_0_0_0_0_1_0_0, 3'd3, 8'b0000_0010, 5);
        // LD with run dropped in MEM: completes, then IDLE
        add("rd_if",    9'b1_1_0_1_1_0_0_0_0, 3'd1, 8'b1100_0000, 6);
        add("rd_id",    9'b1_1_0_1_1_0_0_0_0, 3'd2, 8'b0000_0000, 6);
        add("rd_ex",    9'b1_1_0_1_1_0_0_0_0, 3'd3, 8'b0000_0000, 6);
        add("rd_mem0",  9'b0_1_0_1_1_0_0_0_0, 3'd4, 8'b0010_0000, 6);
        add("rd_mem1",  9'b0_1_1_1_1_0_0_0_0, 3'd4, 8'b0010_0000, 6);
        add("rd_wb",    9'b0_1_0_1_1_0_0_0_0, 3'd5, 8'b0000_1010, 6);
        add("rd_idle0", 9'b0_1_1_1_1_0_0_0_0, 3'd0, 8'b0000_0000, 7);
        add("rd_idle1", 9'b0_1_1_1_1_0_0_0_0, 3'd0, 8'b0000_0000, 7);

        foreach (vq[i]) begin
            apply(vq[i].in);
            #1;
            chk({vq[i].name, "_state"}, 32'(state), 32'(vq[i].st));
            chk({vq[i].name, "_outs"}, 32'(dut_outs()), 32'(vq[i].outs));
            chk({vq[i].name, "_retired"}, 32'(retired), 32'(vq[i].ret));
            step();
        end

        // Fetch timeout: no ready for WAIT_MAX+1 IF cycles -> FAULT
        do_reset();
        apply(9'b1_0_0_0_0_0_0_0_0);
        step();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_if%0d_state", i), 32'(state), 32'd1);
            chk($sformatf("to_if%0d_req", i), 32'(imem_req), 32'd1);
            step();
        end
        chk("to_fault_state", 32'(state), 32'd6);
        chk("to_fault_flag", 32'(fault), 32'd1);
        chk("to_fault_outs", 32'(dut_outs()), 32'd0);
        apply(9'b1_1_1_1_0_0_0_1_0);
        for (int i = 0; i < 3; i++) step();
        chk("to_sticky_state", 32'(state), 32'd6);
        chk("to_sticky_outs", 32'(dut_outs()), 32'd0);

        // Ready in the very cycle the counter reaches WAIT_MAX: no fault
        do_reset();
        apply(9'b1_0_0_0_0_0_0_0_0);
        step();
        for (int i = 0; i < 15; i++) step();
        chk("lim_state", 32'(state), 32'd1);
        apply(9'b1_1_0_0_0_0_0_0_0);
        #1;
        chk("lim_outs", 32'(dut_outs()), 32'hC0);
        step();
        chk("lim_next_state", 32'(state), 32'd2);
        chk("lim_fault", 32'(fault), 32'd0);

        // Async reset in EX after one retire
        do_reset();
        apply(9'b1_1_0_1_0_0_0_1_0);
        for (int i = 0; i < 5; i++) step();
        step(); step();
        chk("rst_pre_state", 32'(state), 32'd3);
        chk("rst_pre_retired", 32'(retired), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_state", 32'(state), 32'd0);
        chk("rst_async_retired", 32'(retired), 32'd0);
        chk("rst_async_outs", 32'(dut_outs()), 32'd0);
        apply(9'b0_1_0_1_0_0_0_1_0);
        step();
        rst = 1'b0;
        step();
        chk("rst_after_state", 32'(state), 32'd0);
        chk("rst_after_outs", 32'(dut_outs()), 32'd0);
        chk("rst_after_retired", 32'(retired), 32'd0);

        // Counter wrap: 16 branches on the CNT_W=4 instance
        do_reset();
        apply(9'b1_1_0_0_0_0_1_0_1);
        begin
            bit seen15 = 1'b0;
            for (int c = 0; c < 200 && retired != 16'd16; c++) begin
                if (retired == 16'd15 && !seen15) begin
                    seen15 = 1'b1;
                    chk("wrap_at15", 32'(x_retired), 32'd15);
                end
                step();
            end
        end
        chk("wrap_main16", 32'(retired), 32'd16);
        chk("wrap_narrow0", 32'(x_retired), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the ONC-16 core.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Consumes the instruction decoder's classification signals, the flag-register branch result and the memory ready handshakes.
- Drives the instruction-register, PC, register-file, flag-register and memory enables, so the combinational decode outputs are committed only in the correct cycle.

Parameters:
- WAIT_MAX, 15: maximum cycles a memory request may stay unacknowledged before a fault.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = execute; sampled only at instruction boundaries.
- imem_ready  in  1  instruction memory has returned a word.
- dmem_ready  in  1  data memory has completed the access.
- dec_rf_we  in  1  decoder: instruction writes the register file.
- dec_is_ld  in  1  decoder: LD instruction.
- dec_is_st  in  1  decoder: ST instruction.
- dec_fr_de  in  1  decoder: branch instruction.
- dec_fr_upd  in  1  decoder: instruction updates flags (ALU ops, CMP, CMPI).
- br_taken  in  1  flag register: branch condition true.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  instruction register load strobe.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (valid with dmem_req).
- rf_we  out  1  register file write strobe.
- fr_we  out  1  flag register write strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+1, 1 = branch target.
- retired  out  CNT_W  retired-instruction count.
- fault  out  1  memory timeout occurred (sticky).
- state  out  3  current state, for debug.

Behaviour:
- States and encodings: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, FAULT=6.
- Reset (async) values: state=IDLE; retired=0; fault=0; all strobes and requests 0; pc_sel=0; wait counter 0.
- IDLE: all outputs 0. Goes to IF in the cycle after run=1 is sampled.
- IF:
  - imem_req=1 is held until imem_ready=1.
  - In the cycle imem_ready=1, ir_we=1 (one-cycle pulse); next state is ID.
- ID: one cycle with no strobes; decoder outputs settle from the new IR. Next state is EX.
- EX, branch (dec_fr_de=1):
  - pc_we=1 and pc_sel=br_taken this cycle.
  - retired increments; state goes to the boundary.
- EX, load/store (dec_is_ld or dec_is_st): next state is MEM.
- EX, otherwise: next state is WB.
- MEM:
  - dmem_req=1 and dmem_we=dec_is_st are held until dmem_ready=1.
  - ST completes in the dmem_ready cycle: pc_we=1, pc_sel=0, retired increments, go to the boundary.
  - LD goes to WB on dmem_ready, so read data is written one cycle after the memory acknowledges it.
- WB, single cycle:
  - rf_we=dec_rf_we (1 for LD); fr_we=dec_fr_upd.
  - pc_we=1, pc_sel=0; retired increments; go to the boundary.
  - CMP/CMPI therefore give rf_we=0 and fr_we=1.
- Boundary: next state is IF if run=1, otherwise IDLE. Deasserting run never aborts an instruction mid-flight.
- Mutual exclusion:
  - Exactly one pc_we pulse per retired instruction; rf_we and pc_we share the commit cycle.
  - pc_sel is meaningful only while pc_we=1 and is 0 otherwise.
  - dec_is_ld and dec_is_st both 1 is illegal; treat as LD.
- Wait counter:
  - Cleared on entry to IF or MEM; increments each cycle the request is held without ready.
  - If it reaches WAIT_MAX with ready still 0, next state is FAULT.
  - A ready in the same cycle the count hits WAIT_MAX wins: normal completion, no fault.
- FAULT: fault=1 and all strobes and requests 0. Exits only on rst.
- retired wraps modulo 2^CNT_W with no saturation.
- rst asserted mid-instruction: all outputs drop immediately (async); no partial commit strobe is emitted afterwards.

Test Plan:
- ADD, imem_ready immediate, run=1: states IF,ID,EX,WB = 4 cycles; WB cycle has rf_we=1, fr_we=1, pc_we=1, pc_sel=0; retired 0->1.
- LD with dmem_ready after 3 wait cycles: dmem_req high 4 cycles with dmem_we=0; WB follows with rf_we=1; total 8 cycles; one pc_we pulse.
- ST then CMPI: ST commits in the MEM ready cycle with dmem_we=1, rf_we=0. CMPI WB gives rf_we=0, fr_we=1. retired=2.
- Branch with br_taken=1, then br_taken=0: EX pc_we=1 with pc_sel=1, then pc_sel=0; no rf_we/fr_we; 3 cycles each.
- Timeout, WAIT_MAX=15, imem_ready held 0: FAULT entered after 15 wait cycles; fault=1; imem_req=0 thereafter. Ready exactly at the 15th wait cycle gives normal completion instead.
- Control corner cases:
  - run dropped during MEM: instruction completes, then IDLE.
  - rst pulsed in EX: state=0, retired=0 asynchronously.
  - CNT_W=4 with 16 retires: retired wraps to 0.
